// File: rtl/gecko_system_sequencer.sv
// gecko_system_sequencer
//   Serializes system commands (CSR reads and ENV ops) between issue and the
//   gecko system unit. Each accepted command is held until the execute pipe
//   has been quiet (inflight==0) for MIN_DRAIN consecutive cycles. This keeps
//   CYCLE/INSTRET reads exact. ENV ops (ECALL/EBREAK) are consumed here and
//   park the block in a sticky HALTED state until reset.
//
// Optional feature macro: GECKO_SYSTEM_SEQUENCER_STATS_EN
//   Adds the stall_cycles_o counter. It counts DRAIN cycles and cycles in
//   ISSUE that wait on back-pressure.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   inflight_i              issued-but-not-retired count from the core
//   command_in_*            valid/ready/payload stream from issue
//   command_out_*           valid/ready/payload stream to the system unit
//   busy_o                  state != IDLE (issue stalls on it)
//   halted_o                sticky, an ENV op was consumed
//   timeout_error_o         sticky, a command was force-issued after DRAIN_TIMEOUT
//   stall_cycles_o          (STATS_EN only) free-running 32-bit stall count

package gecko_system_sequencer_pkg;
  localparam logic [2:0] RV32I_FUNCT3_SYS_ENV = 3'b000;

  typedef struct packed {
    logic [2:0]  sys_op;    // funct3 of the SYSTEM opcode
    logic [11:0] csr_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [31:0] wdata;
  } gecko_system_operation_t;
endpackage

module gecko_system_sequencer
  import gecko_system_sequencer_pkg::*;
#(
  parameter int INFLIGHT_WIDTH = 4,
  parameter int MIN_DRAIN      = 1,
  parameter int DRAIN_TIMEOUT  = 1023
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [INFLIGHT_WIDTH-1:0] inflight_i,
  input  logic                      command_in_valid_i,
  output logic                      command_in_ready_o,
  input  gecko_system_operation_t   command_in_payload_i,
  output logic                      command_out_valid_o,
  input  logic                      command_out_ready_i,
  output gecko_system_operation_t   command_out_payload_o,
`ifdef GECKO_SYSTEM_SEQUENCER_STATS_EN
  output logic [31:0]               stall_cycles_o,
`endif
  output logic                      busy_o,
  output logic                      halted_o,
  output logic                      timeout_error_o
);

  localparam int WAIT_W = (DRAIN_TIMEOUT < 1) ? 1 : $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [3:0]        MIN_Q  = 4'(MIN_DRAIN);
  localparam logic [WAIT_W-1:0] TO_CNT = WAIT_W'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, HALTED} state_t;

  state_t                  state_q;
  gecko_system_operation_t held_q;
  logic [3:0]              quiet_q, quiet_inc, quiet_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    timeout_q;
  logic                    quiet_done, timeout_hit, held_is_env;

  // Completion is judged on the post-increment count so that a quiet first
  // DRAIN cycle with MIN_DRAIN=1 issues on the very next cycle.
  assign quiet_inc  = quiet_q + 4'd1;
  assign quiet_done = (inflight_i == '0) && (quiet_inc >= MIN_Q);

  always_comb begin
    quiet_d = quiet_inc;
    if (inflight_i != '0)    quiet_d = '0;   // any activity restarts the window
    else if (quiet_q >= MIN_Q) quiet_d = MIN_Q;
  end

  assign wait_d      = wait_q + WAIT_W'(1);
  assign timeout_hit = (DRAIN_TIMEOUT != 0) && (wait_d == TO_CNT);
  assign held_is_env = (held_q.sys_op == RV32I_FUNCT3_SYS_ENV);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      held_q    <= '0;
      quiet_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (command_in_valid_i) begin
          held_q  <= command_in_payload_i;
          quiet_q <= '0;
          wait_q  <= '0;
          state_q <= DRAIN;
        end
        DRAIN: begin
          quiet_q <= quiet_d;
          wait_q  <= wait_d;
          // Quiet completion takes priority over the timeout.
          if (quiet_done) begin
            state_q <= held_is_env ? HALTED : ISSUE;
          end else if (timeout_hit) begin
            timeout_q <= 1'b1;
            state_q   <= held_is_env ? HALTED : ISSUE;
          end
        end
        ISSUE: if (command_out_ready_i) state_q <= IDLE;
        HALTED: state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef GECKO_SYSTEM_SEQUENCER_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if ((state_q == DRAIN) ||
                 ((state_q == ISSUE) && !command_out_ready_i)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

  // Handshake outputs come from state only; reset just masks ready.
  assign command_in_ready_o    = (state_q == IDLE) && !rst_i;
  assign command_out_valid_o   = (state_q == ISSUE);
  assign command_out_payload_o = held_q;
  assign busy_o                = (state_q != IDLE);
  assign halted_o              = (state_q == HALTED);
  assign timeout_error_o       = timeout_q;

endmodule

// File: tb/tb_gecko_system_sequencer.sv
module tb_gecko_system_sequencer;
  import gecko_system_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  // DUT a: MIN_DRAIN=1, default timeout. DUT b: MIN_DRAIN=2, DRAIN_TIMEOUT=8.
  logic [3:0] inflight_a, inflight_b;
  logic cin_valid_a, cin_valid_b, cin_ready_a, cin_ready_b;
  logic cout_valid_a, cout_valid_b, cout_ready_a, cout_ready_b;
  gecko_system_operation_t cin_pay_a, cin_pay_b, cout_pay_a, cout_pay_b;
  logic busy_a, busy_b, halted_a, halted_b, tmo_a, tmo_b;
`ifdef GECKO_SYSTEM_SEQUENCER_STATS_EN
  logic [31:0] stall_a, stall_b, s0;
`endif

  int errors = 0;
  int checks = 0;
  gecko_system_operation_t q_a[$];
  gecko_system_operation_t q_b[$];

  gecko_system_sequencer #(.INFLIGHT_WIDTH(4), .MIN_DRAIN(1), .DRAIN_TIMEOUT(1023)) u_a (
    .clk_i(clk), .rst_i(rst), .inflight_i(inflight_a),
    .command_in_valid_i(cin_valid_a), .command_in_ready_o(cin_ready_a),
    .command_in_payload_i(cin_pay_a),
    .command_out_valid_o(cout_valid_a), .command_out_ready_i(cout_ready_a),
    .command_out_payload_o(cout_pay_a),
`ifdef GECKO_SYSTEM_SEQUENCER_STATS_EN
    .stall_cycles_o(stall_a),
`endif
    .busy_o(busy_a), .halted_o(halted_a), .timeout_error_o(tmo_a));

  gecko_system_sequencer #(.INFLIGHT_WIDTH(4), .MIN_DRAIN(2), .DRAIN_TIMEOUT(8)) u_b (
    .clk_i(clk), .rst_i(rst), .inflight_i(inflight_b),
    .command_in_valid_i(cin_valid_b), .command_in_ready_o(cin_ready_b),
    .command_in_payload_i(cin_pay_b),
    .command_out_valid_o(cout_valid_b), .command_out_ready_i(cout_ready_b),
    .command_out_payload_o(cout_pay_b),
`ifdef GECKO_SYSTEM_SEQUENCER_STATS_EN
    .stall_cycles_o(stall_b),
`endif
    .busy_o(busy_b), .halted_o(halted_b), .timeout_error_o(tmo_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic gecko_system_operation_t mk(input logic [2:0] op, input logic [11:0] csr,
                                                 input logic [4:0] rd, input logic [31:0] wd);
    gecko_system_operation_t r;
    r = '{sys_op: op, csr_addr: csr, rd_addr: rd, rs1_addr: 5'd1, wdata: wd};
    return r;
  endfunction

  // Scoreboard monitors: every output handshake must match the oldest expected command.
  always @(negedge clk) begin
    if (!rst && cout_valid_a && cout_ready_a) begin
      checks++;
      assert (q_a.size() > 0) else begin
        errors++;
        $error("FAIL a_unexpected_out observed=%0h expected=none", cout_pay_a);
      end
      if (q_a.size() > 0) chk("a_payload", 64'(cout_pay_a), 64'(q_a.pop_front()));
    end
    if (!rst && cout_valid_b && cout_ready_b) begin
      checks++;
      assert (q_b.size() > 0) else begin
        errors++;
        $error("FAIL b_unexpected_out observed=%0h expected=none", cout_pay_b);
      end
      if (q_b.size() > 0) chk("b_payload", 64'(cout_pay_b), 64'(q_b.pop_front()));
    end
  end

  gecko_system_operation_t p;

  initial begin
    rst = 1'b1;
    inflight_a = '0; inflight_b = '0;
    cin_valid_a = 1'b0; cin_valid_b = 1'b0;
    cin_pay_a = '0; cin_pay_b = '0;
    cout_ready_a = 1'b0; cout_ready_b = 1'b0;
    tick(2);

    // Reset state
    chk("rst_busy", 64'(busy_a), 0);
    chk("rst_valid", 64'(cout_valid_a), 0);
    chk("rst_halted", 64'(halted_a), 0);
    chk("rst_timeout", 64'(tmo_b), 0);
    chk("rst_ready_masked", 64'(cin_ready_a), 0);
    chk("rst_payload", 64'(cout_pay_a), 0);
`ifdef GECKO_SYSTEM_SEQUENCER_STATS_EN
    chk("rst_stall", 64'(stall_a), 0);
`endif
    rst = 1'b0; #1;
    chk("idle_ready_a", 64'(cin_ready_a), 1);
    chk("idle_ready_b", 64'(cin_ready_b), 1);

    // Test 1: CSRRS CYCLE rd=5, inflight=0, MIN_DRAIN=1
    p = mk(3'b010, 12'hC00, 5'd5, 32'h0);
    cin_pay_a = p; cin_valid_a = 1'b1; cout_ready_a = 1'b1;
    chk("t1_ready_accept", 64'(cin_ready_a), 1);
    q_a.push_back(p);
    tick();                                   // N+1: DRAIN
    p = mk(3'b100, 12'h123, 5'd0, 32'hDEAD_BEEF); // unknown funct3, rd=0: forwarded as-is
    cin_pay_a = p;
    chk("t1_drain_busy", 64'(busy_a), 1);
    chk("t1_drain_valid", 64'(cout_valid_a), 0);
    chk("t1_drain_ready", 64'(cin_ready_a), 0);
    tick();                                   // N+2: ISSUE
    chk("t1_issue_valid", 64'(cout_valid_a), 1);
    chk("t1_issue_busy", 64'(busy_a), 1);
    tick();                                   // N+3: IDLE, second command taken
    chk("t1_idle_busy", 64'(busy_a), 0);
    chk("t1_idle_ready", 64'(cin_ready_a), 1);
    q_a.push_back(p);
    tick();
    cin_valid_a = 1'b0;
    chk("t1b_drain_valid", 64'(cout_valid_a), 0);
    tick();
    chk("t1b_issue_valid", 64'(cout_valid_a), 1);
    tick();
    chk("t1b_idle_busy", 64'(busy_a), 0);

    // Test 3: back-pressure in ISSUE for 4 cycles
`ifdef GECKO_SYSTEM_SEQUENCER_STATS_EN
    s0 = stall_a;
`endif
    cout_ready_a = 1'b0;
    p = mk(3'b011, 12'hC02, 5'd7, 32'h5A5A_0001);
    cin_pay_a = p; cin_valid_a = 1'b1;
    q_a.push_back(p);
    tick();
    cin_valid_a = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_valid", 64'(cout_valid_a), 1);
      chk("t3_hold_payload", 64'(cout_pay_a), 64'(p));
      chk("t3_hold_in_ready", 64'(cin_ready_a), 0);
      if (i == 3) cout_ready_a = 1'b1;
      else tick();
    end
    tick();
    chk("t3_idle_busy", 64'(busy_a), 0);
    chk("t3_idle_ready", 64'(cin_ready_a), 1);
`ifdef GECKO_SYSTEM_SEQUENCER_STATS_EN
    chk("t3_stall_delta", 64'(stall_a - s0), 4);
`endif

    // Test 4: ENV op halts; no forward
    p = mk(RV32I_FUNCT3_SYS_ENV, 12'h000, 5'd0, 32'h0);
    cin_pay_a = p; cin_valid_a = 1'b1;
    tick();
    cin_pay_a = mk(3'b001, 12'h340, 5'd3, 32'h1234);
    chk("t4_drain_halted", 64'(halted_a), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t4_halted", 64'(halted_a), 1);
      chk("t4_busy", 64'(busy_a), 1);
      chk("t4_no_valid", 64'(cout_valid_a), 0);
      chk("t4_in_ready", 64'(cin_ready_a), 0);
      tick();
    end
    cin_valid_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("t4_rst_halted", 64'(halted_a), 0);
    chk("t4_rst_ready", 64'(cin_ready_a), 1);

    // Test 6: reset during ISSUE with ready low drops the command
    cout_ready_a = 1'b0;
    cin_pay_a = mk(3'b010, 12'hC01, 5'd9, 32'h0); cin_valid_a = 1'b1;
    tick();
    cin_valid_a = 1'b0;
    tick();
    chk("t6_issue_valid", 64'(cout_valid_a), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("t6_valid", 64'(cout_valid_a), 0);
    chk("t6_busy", 64'(busy_a), 0);
    chk("t6_ready", 64'(cin_ready_a), 1);
`ifdef GECKO_SYSTEM_SEQUENCER_STATS_EN
    chk("t6_stall", 64'(stall_a), 0);
`endif
    cout_ready_a = 1'b1;
    tick(3);
    chk("t6_still_idle", 64'(busy_a), 0);

    // Test 2: MIN_DRAIN=2, inflight busy for 4 DRAIN cycles then 0
    cout_ready_b = 1'b1;
    inflight_b = 4'd3;
    p = mk(3'b010, 12'hC00, 5'd11, 32'h0);
    cin_pay_b = p; cin_valid_b = 1'b1;
    q_b.push_back(p);
    tick();                                   // C+1 DRAIN
    cin_valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_busy_no_valid", 64'(cout_valid_b), 0);
      tick();
    end
    inflight_b = 4'd0;                        // C+5 first quiet cycle
    chk("t2_q1_no_valid", 64'(cout_valid_b), 0);
    tick();
    chk("t2_q2_no_valid", 64'(cout_valid_b), 0);
    tick();
    chk("t2_valid", 64'(cout_valid_b), 1);
    chk("t2_no_timeout", 64'(tmo_b), 0);
    tick();

    // Test 2b: one-cycle glitch restarts the window
    p = mk(3'b110, 12'hC02, 5'd12, 32'h0);
    cin_pay_b = p; cin_valid_b = 1'b1;
    q_b.push_back(p);
    tick();                                   // C+1 quiet
    cin_valid_b = 1'b0;
    tick();                                   // C+2 glitch
    inflight_b = 4'd1;
    tick();                                   // C+3
    inflight_b = 4'd0;
    chk("t2g_c3_no_valid", 64'(cout_valid_b), 0);
    tick();
    chk("t2g_c4_no_valid", 64'(cout_valid_b), 0);
    tick();
    chk("t2g_valid", 64'(cout_valid_b), 1);
    tick();

    // Quiet completion and timeout in the same cycle: no timeout flag
    inflight_b = 4'd3;
    p = mk(3'b010, 12'hB00, 5'd13, 32'h0);
    cin_pay_b = p; cin_valid_b = 1'b1;
    q_b.push_back(p);
    tick();                                   // C+1
    cin_valid_b = 1'b0;
    tick(6);                                  // C+7
    inflight_b = 4'd0;
    tick();                                   // C+8: quiet=2 and wait=8
    chk("tp_c8_no_valid", 64'(cout_valid_b), 0);
    tick();
    chk("tp_valid", 64'(cout_valid_b), 1);
    chk("tp_no_timeout", 64'(tmo_b), 0);
    tick();

    // Test 5: inflight stuck, DRAIN_TIMEOUT=8 forces issue
    inflight_b = 4'd2;
    p = mk(3'b010, 12'hC00, 5'd14, 32'h0);
    cin_pay_b = p; cin_valid_b = 1'b1;
    q_b.push_back(p);
    tick();                                   // C+1
    cin_valid_b = 1'b0;
    tick(7);                                  // C+8
    chk("t5_c8_no_valid", 64'(cout_valid_b), 0);
    chk("t5_c8_no_timeout", 64'(tmo_b), 0);
    tick();                                   // C+9
    chk("t5_valid", 64'(cout_valid_b), 1);
    chk("t5_timeout", 64'(tmo_b), 1);
    tick();                                   // C+10 IDLE
    inflight_b = 4'd0;
    p = mk(3'b001, 12'h340, 5'd15, 32'hCAFE_F00D);
    cin_pay_b = p; cin_valid_b = 1'b1;
    q_b.push_back(p);
    tick();
    cin_valid_b = 1'b0;
    tick();
    chk("t5b_no_valid", 64'(cout_valid_b), 0);
    tick();
    chk("t5b_valid", 64'(cout_valid_b), 1);
    chk("t5b_timeout_sticky", 64'(tmo_b), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("t5_rst_timeout", 64'(tmo_b), 0);

    tick(2);
    chk("a_drained", 64'(q_a.size()), 0);
    chk("b_drained", 64'(q_b.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
